// File: rtl/sfp_acc.sv
// Special-function accumulator: sums len_kij psum vectors per output pixel with
// per-lane signed saturation, optional ReLU, and a registered result vector.
module sfp_acc #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int len_kij = 9,
  localparam int cnt_w  = (len_kij > 1) ? $clog2(len_kij) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     acc,
  input  logic                     relu_en,
  input  logic [col*psum_bw-1:0]   data_in,
  output logic [col*psum_bw-1:0]   sfp_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic [cnt_w-1:0]         kij_cnt,
  output logic                     ovf
);

  localparam logic [cnt_w-1:0] last_beat = cnt_w'(len_kij - 1);

  logic [col*psum_bw-1:0] acc_reg;
  logic [col*psum_bw-1:0] next_sum;
  logic [col*psum_bw-1:0] relu_sum;
  logic [col-1:0]         lane_sat;
  logic                   first_beat;
  logic                   final_beat;

  assign first_beat = (kij_cnt == '0);
  assign final_beat = (kij_cnt == last_beat);
  assign busy       = (kij_cnt != '0);

  // The first beat of a pixel loads data_in as-is, so it can never clamp.
  for (genvar c = 0; c < col; c++) begin : g_lane
    logic [psum_bw-1:0] a;
    logic [psum_bw-1:0] d;
    logic [psum_bw:0]   wide;
    logic               over;
    logic [psum_bw-1:0] clamped;
    logic [psum_bw-1:0] s;

    assign a       = acc_reg[c*psum_bw +: psum_bw];
    assign d       = data_in[c*psum_bw +: psum_bw];
    assign wide    = {a[psum_bw-1], a} + {d[psum_bw-1], d};
    assign over    = wide[psum_bw] ^ wide[psum_bw-1];
    assign clamped = wide[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                   : {1'b0, {(psum_bw-1){1'b1}}};
    assign s       = first_beat ? d : (over ? clamped : wide[psum_bw-1:0]);

    assign lane_sat[c]                     = ~first_beat & over;
    assign next_sum[c*psum_bw +: psum_bw]  = s;
    assign relu_sum[c*psum_bw +: psum_bw]  = s[psum_bw-1] ? '0 : s;
  end

  // clear outranks acc; sfp_out survives clear and only changes on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg   <= '0;
      sfp_out   <= '0;
      out_valid <= 1'b0;
      kij_cnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear) begin
        kij_cnt <= '0;
        acc_reg <= '0;
        ovf     <= 1'b0;
      end else if (acc) begin
        if (|lane_sat) begin
          ovf <= 1'b1;
        end
        if (final_beat) begin
          kij_cnt   <= '0;
          acc_reg   <= '0;
          sfp_out   <= relu_en ? relu_sum : next_sum;
          out_valid <= 1'b1;
        end else begin
          kij_cnt <= kij_cnt + 1'b1;
          acc_reg <= next_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_sfp_acc.sv
// Self-checking bench for sfp_acc: directed scenarios plus randomized pixels,
// all checked against an integer reference model of the accumulation rules.
module tb_sfp_acc;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int LEN = 9;
  localparam int W   = COL * BW;

  logic         clk;
  logic         reset;
  logic         clear;
  logic         acc;
  logic         relu_en;
  logic [W-1:0] data_in;
  logic [W-1:0] sfp_out;
  logic         out_valid;
  logic         busy;
  logic [3:0]   kij_cnt;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           m_sum [COL];
  logic [3:0]   m_cnt;
  logic         m_ovf;
  logic         m_valid;
  logic [W-1:0] m_out;

  sfp_acc #(.col(COL), .psum_bw(BW), .len_kij(LEN)) dut (
    .clk(clk), .reset(reset), .clear(clear), .acc(acc), .relu_en(relu_en),
    .data_in(data_in), .sfp_out(sfp_out), .out_valid(out_valid),
    .busy(busy), .kij_cnt(kij_cnt), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] splat(input int v);
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] lane_vec(input int lane, input int v);
    logic [W-1:0] r;
    r = '0;
    r[lane*BW +: BW] = BW'(v);
    return r;
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt   = '0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_out   = '0;
  endtask

  // One clock: drive inputs, step past the edge, then advance the model.
  task automatic drive(input bit a, input logic [W-1:0] d, input bit r, input bit clr);
    int x;
    int s;
    acc = a; data_in = d; relu_en = r; clear = clr;
    @(posedge clk); #1;
    acc = 1'b0; clear = 1'b0;
    m_valid = 1'b0;
    if (clr) begin
      m_cnt = '0;
      m_ovf = 1'b0;
    end else if (a) begin
      for (int c = 0; c < COL; c++) begin
        x = int'($signed(d[c*BW +: BW]));
        if (m_cnt == 0) s = x;
        else begin
          s = sat(m_sum[c] + x);
          if (s != m_sum[c] + x) m_ovf = 1'b1;
        end
        m_sum[c] = s;
        if (m_cnt == 4'(LEN - 1)) m_out[c*BW +: BW] = (r && s < 0) ? '0 : BW'(s);
      end
      if (m_cnt == 4'(LEN - 1)) begin
        m_cnt   = '0;
        m_valid = 1'b1;
      end else begin
        m_cnt = m_cnt + 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; acc = 1'b0; relu_en = 1'b0; data_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, kij_cnt, ovf, sfp_out} !== {1'b0, 1'b0, 4'd0, 1'b0, {W{1'b0}}}) begin
      failures++;
      $display("[TB] FAIL reset_state: got valid=%b busy=%b cnt=%0d ovf=%b out=%h, expected all zero",
               out_valid, busy, kij_cnt, ovf, sfp_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_sum();
    for (int i = 1; i <= LEN; i++) begin
      drive(1'b1, lane_vec(0, i), 1'b0, 1'b0);
      checks++;
      if ({out_valid, busy, kij_cnt, ovf, sfp_out} !== {m_valid, m_cnt != 0, m_cnt, m_ovf, m_out}) begin
        failures++;
        $display("[TB] FAIL basic_sum beat %0d: got valid=%b busy=%b cnt=%0d ovf=%b out=%h, expected valid=%b cnt=%0d ovf=%b out=%h",
                 i, out_valid, busy, kij_cnt, ovf, sfp_out, m_valid, m_cnt, m_ovf, m_out);
      end
    end
    checks++;
    if (sfp_out !== lane_vec(0, 45) || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_sum_value: got out=%h ovf=%b, expected out=%h ovf=0", sfp_out, ovf, lane_vec(0, 45));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_valid_pulse: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_relu();
    logic [W-1:0] want [2];
    want[0] = splat(0);
    want[1] = splat(-27);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < LEN; i++) drive(1'b1, splat(-3), p == 0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || sfp_out !== want[p] || sfp_out !== m_out) begin
        failures++;
        $display("[TB] FAIL relu pass %0d: got valid=%b out=%h, expected valid=1 out=%h", p, out_valid, sfp_out, want[p]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] v;
    logic [W-1:0] want;
    v = lane_vec(0, 16'h7000) | lane_vec(1, 16'h9000);
    want = lane_vec(0, 16'h7FFF) | lane_vec(1, 16'h8000);
    for (int i = 0; i < LEN; i++) drive(1'b1, v, 1'b0, 1'b0);
    checks++;
    if (sfp_out !== want || ovf !== 1'b1 || sfp_out !== m_out) begin
      failures++;
      $display("[TB] FAIL saturation: got out=%h ovf=%b, expected out=%h ovf=1", sfp_out, ovf, want);
    end
    for (int i = 0; i < LEN; i++) drive(1'b1, splat(1), 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b1 || sfp_out !== splat(9)) begin
      failures++;
      $display("[TB] FAIL ovf_sticky: got ovf=%b out=%h, expected ovf=1 out=%h", ovf, sfp_out, splat(9));
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b0 || sfp_out !== splat(9)) begin
      failures++;
      $display("[TB] FAIL ovf_clear: got ovf=%b out=%h, expected ovf=0 out=%h", ovf, sfp_out, splat(9));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 2 * LEN; k++) begin
      drive(1'b1, splat(k <= LEN ? 1 : 2), 1'b0, 1'b0);
      checks++;
      if (out_valid !== (k == LEN || k == 2 * LEN) || kij_cnt !== m_cnt || sfp_out !== m_out) begin
        failures++;
        $display("[TB] FAIL back_to_back beat %0d: got valid=%b cnt=%0d out=%h, expected valid=%b cnt=%0d out=%h",
                 k, out_valid, kij_cnt, sfp_out, (k == LEN || k == 2 * LEN), m_cnt, m_out);
      end
      if (k == LEN || k == 2 * LEN) begin
        checks++;
        if (sfp_out !== splat(k == LEN ? 9 : 18)) begin
          failures++;
          $display("[TB] FAIL back_to_back_value beat %0d: got %h, expected %h", k, sfp_out, splat(k == LEN ? 9 : 18));
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] beats [LEN];
    logic [W-1:0] ref_out;
    for (int i = 0; i < LEN; i++) beats[i] = {$urandom, $urandom, $urandom, $urandom} & splat(16'h0FFF);
    for (int i = 0; i < LEN; i++) drive(1'b1, beats[i], 1'b0, 1'b0);
    ref_out = sfp_out;
    for (int i = 0; i < LEN; i++) begin
      drive(1'b1, beats[i], 1'b0, 1'b0);
      for (int g = $urandom_range(3, 0); g > 0; g--) begin
        drive(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        checks++;
        if ({out_valid, busy, kij_cnt} !== {1'b0, m_cnt != 0, m_cnt}) begin
          failures++;
          $display("[TB] FAIL gap_hold beat %0d: got valid=%b busy=%b cnt=%0d, expected valid=0 busy=%b cnt=%0d",
                   i, out_valid, busy, kij_cnt, m_cnt != 0, m_cnt);
        end
      end
    end
    checks++;
    if (sfp_out !== ref_out || sfp_out !== m_out) begin
      failures++;
      $display("[TB] FAIL gap_result: got %h, expected %h", sfp_out, m_out);
    end
  endtask

  task automatic test_abort();
    bit seen_valid;
    for (int i = 0; i < 4; i++) drive(1'b1, splat(7), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (kij_cnt !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_abort: got cnt=%0d busy=%b, expected cnt=0 busy=0", kij_cnt, busy);
    end
    for (int i = 0; i < 5; i++) drive(1'b1, splat(7), 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    checks++;
    if ({kij_cnt, busy, sfp_out} !== {4'd0, 1'b0, {W{1'b0}}}) begin
      failures++;
      $display("[TB] FAIL async_reset: got cnt=%0d busy=%b out=%h, expected cnt=0 busy=0 out=0", kij_cnt, busy, sfp_out);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      drive(1'b1, splat(1), 1'b0, 1'b0);
      if (i < LEN - 1 && out_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid || out_valid !== 1'b1 || sfp_out !== splat(9)) begin
      failures++;
      $display("[TB] FAIL fresh_after_abort: early_valid=%b valid=%b out=%h, expected early_valid=0 valid=1 out=%h",
               seen_valid, out_valid, sfp_out, splat(9));
    end
    drive(1'b1, splat(3), 1'b0, 1'b0);
    drive(1'b1, splat(3), 1'b0, 1'b1);
    checks++;
    if (kij_cnt !== 4'd0 || kij_cnt !== m_cnt) begin
      failures++;
      $display("[TB] FAIL clear_and_acc: got cnt=%0d, expected 0", kij_cnt);
    end
  endtask

  task automatic test_random();
    bit a, r, clr;
    logic [W-1:0] d;
    for (int n = 0; n < 400; n++) begin
      a   = ($urandom_range(3, 0) != 0);
      r   = $urandom_range(1, 0);
      clr = ($urandom_range(40, 0) == 0);
      d   = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(1, 0) == 1) d = d & splat(16'h00FF);
      drive(a, d, r, clr);
      checks++;
      if ({out_valid, busy, kij_cnt, ovf, sfp_out} !== {m_valid, m_cnt != 0, m_cnt, m_ovf, m_out}) begin
        failures++;
        $display("[TB] FAIL random step %0d: got valid=%b busy=%b cnt=%0d ovf=%b out=%h, expected valid=%b cnt=%0d ovf=%b out=%h",
                 n, out_valid, busy, kij_cnt, ovf, sfp_out, m_valid, m_cnt, m_ovf, m_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_relu();
    test_saturation();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
